// File: rtl/car_park_occupancy.sv
// rtl/car_park_occupancy.sv - saturating car park occupancy counter with incremental BCD and sticky errors
module car_park_occupancy #(
  parameter int CAPACITY = 150
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       exit,
  input  logic       clr,
  output logic [9:0] count,
  output logic [9:0] free,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       full,
  output logic       empty,
  output logic       err_over,
  output logic       err_under
);

  localparam logic [9:0] CAP = 10'(CAPACITY);

  logic [3:0] inc2, inc1, inc0;
  logic [3:0] dec2, dec1, dec0;
  logic       units_nine, tens_nine, units_zero, tens_zero;
  logic       only_enter, only_exit;

  assign units_nine = (bcd0 == 4'd9);
  assign tens_nine  = (bcd1 == 4'd9);
  assign units_zero = (bcd0 == 4'd0);
  assign tens_zero  = (bcd1 == 4'd0);

  assign only_enter = enter & ~exit;
  assign only_exit  = exit & ~enter;

  // Ripple carry/borrow across the three digits in one cycle, so 99 <-> 100 is atomic.
  always_comb begin
    inc0 = bcd0;
    inc1 = bcd1;
    inc2 = bcd2;
    if (units_nine) begin
      inc0 = 4'd0;
      if (tens_nine) begin
        inc1 = 4'd0;
        inc2 = bcd2 + 4'd1;
      end else begin
        inc1 = bcd1 + 4'd1;
      end
    end else begin
      inc0 = bcd0 + 4'd1;
    end
  end

  always_comb begin
    dec0 = bcd0;
    dec1 = bcd1;
    dec2 = bcd2;
    if (units_zero) begin
      dec0 = 4'd9;
      if (tens_zero) begin
        dec1 = 4'd9;
        dec2 = bcd2 - 4'd1;
      end else begin
        dec1 = bcd1 - 4'd1;
      end
    end else begin
      dec0 = bcd0 - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      bcd2      <= '0;
      bcd1      <= '0;
      bcd0      <= '0;
      err_over  <= 1'b0;
      err_under <= 1'b0;
    end else if (clr) begin
      count     <= '0;
      bcd2      <= '0;
      bcd1      <= '0;
      bcd0      <= '0;
      err_over  <= 1'b0;
      err_under <= 1'b0;
    end else if (only_enter) begin
      if (count < CAP) begin
        count <= count + 10'd1;
        bcd2  <= inc2;
        bcd1  <= inc1;
        bcd0  <= inc0;
      end else begin
        err_over <= 1'b1;
      end
    end else if (only_exit) begin
      if (count != 10'd0) begin
        count <= count - 10'd1;
        bcd2  <= dec2;
        bcd1  <= dec1;
        bcd0  <= dec0;
      end else begin
        err_under <= 1'b1;
      end
    end
  end

  // Status flags decode straight from the count register, tracking it with no extra delay.
  assign free  = CAP - count;
  assign full  = (count == CAP);
  assign empty = (count == 10'd0);

endmodule

// File: tb/tb_car_park_occupancy.sv
// tb/tb_car_park_occupancy.sv - directed vector bench for car_park_occupancy
module tb_car_park_occupancy;

  localparam int CAP = 150;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter;
  logic       exit;
  logic       clr;
  logic [9:0] count;
  logic [9:0] free;
  logic [3:0] bcd2, bcd1, bcd0;
  logic       full, empty, err_over, err_under;

  int n_checks = 0;
  int n_errors = 0;

  car_park_occupancy #(.CAPACITY(CAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .enter     (enter),
    .exit      (exit),
    .clr       (clr),
    .count     (count),
    .free      (free),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .full      (full),
    .empty     (empty),
    .err_over  (err_over),
    .err_under (err_under)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic clr;
    logic enter;
    logic exit;
    int   exp_count;
    logic exp_over;
    logic exp_under;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, int c, bit ov, bit un);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".free"}, int'(free), CAP - c);
    chk({tag, ".bcd2"}, int'(bcd2), c / 100);
    chk({tag, ".bcd1"}, int'(bcd1), (c / 10) % 10);
    chk({tag, ".bcd0"}, int'(bcd0), c % 10);
    chk({tag, ".full"}, int'(full), int'(c == CAP));
    chk({tag, ".empty"}, int'(empty), int'(c == 0));
    chk({tag, ".err_over"}, int'(err_over), int'(ov));
    chk({tag, ".err_under"}, int'(err_under), int'(un));
  endtask

  task automatic drive(logic c, logic en, logic ex);
    clr   = c;
    enter = en;
    exit  = ex;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            clr  en   ex   count ov    un
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].clr, vecs[i].enter, vecs[i].exit);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_over, vecs[i].exp_under);
    end

    // Fill to capacity, checking the BCD invariant at every count including 99 -> 100.
    for (int i = 1; i <= CAP; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      step();
      check_all($sformatf("fill%0d", i), i, 1'b0, 1'b0);
      if (i == 100) begin
        drive(1'b0, 1'b0, 1'b1);
        step();
        check_all("wrap_down99", 99, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        step();
        check_all("wrap_up100", 100, 1'b0, 1'b0);
      end
    end

    drive(1'b0, 1'b1, 1'b1);
    step();
    check_all("both_full", CAP, 1'b0, 1'b0);

    drive(1'b0, 1'b1, 1'b0);
    step();
    check_all("over1", CAP, 1'b1, 1'b0);
    step();
    check_all("over2", CAP, 1'b1, 1'b0);

    // Drain to 37 with err_over still latched.
    for (int i = CAP - 1; i >= 37; i--) begin
      drive(1'b0, 1'b0, 1'b1);
      step();
      if (i % 10 == 0 || i == 37)
        check_all($sformatf("drain%0d", i), i, 1'b1, 1'b0);
    end

    drive(1'b1, 1'b1, 1'b0);
    step();
    check_all("clr_at37", 0, 1'b0, 1'b0);

    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      step();
    end
    check_all("pre_async", 5, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Reset pulse strictly between edges must take effect without a clock.
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    step();
    check_all("post_reset", 1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
